// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- dual-lane 64-bit ALU with registered results, a running accumulator,
// a rotating XOR signature, a free-running cycle counter and lane0 flags.
//
// Ports
//   clk       in   1    sole clock, all state updates on posedge
//   rst_n     in   1    asynchronous active-low reset
//   in_flat   in   258  {op[257:256], d[255:192], c[191:128], b[127:64], a[63:0]}
//   out_flat  out  330  {ovf, z, cy, pop[6:0], cnt, sig, acc, r1, r0}
//
// Parameter
//   ACC_INIT  reset value of the accumulator
//
// Build option
//   TOP_ACC_SAT_EN  when defined, the accumulator clamps at all-ones on
//                   carry-out instead of wrapping (ovf still sets).
//
// Op encoding (same for both lanes): 00 add, 01 sub, 10 and, 11 xor.
// ---------------------------------------------------------------------------
module top #(
    parameter logic [63:0] ACC_INIT = 64'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [257:0] in_flat,
    output logic [329:0] out_flat
);

    localparam int DATA_W = 64;

    function automatic logic [DATA_W-1:0] lane_op(input logic [1:0]        op,
                                                  input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] res;
        case (op)
            2'b00:   res = x + y;
            2'b01:   res = x - y;
            2'b10:   res = x & y;
            default: res = x ^ y;
        endcase
        return res;
    endfunction

    function automatic logic [6:0] popcount(input logic [DATA_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

    // Returns {carry_out, next_acc}; carry_out always reflects the raw
    // unsigned addition so ovf behaves the same in both build options.
    function automatic logic [DATA_W:0] acc_add(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] val);
        logic [DATA_W:0] sum;
        sum = {1'b0, acc} + {1'b0, val};
`ifdef TOP_ACC_SAT_EN
        if (sum[DATA_W]) begin
            sum[DATA_W-1:0] = '1;
        end
`endif
        return sum;
    endfunction

    logic [DATA_W-1:0] a, b, c, d;
    logic [1:0]        op;
    logic [DATA_W-1:0] lane0, lane1;
    logic [DATA_W:0]   acc_sum;

    logic [DATA_W-1:0] r0_d, r0_q;
    logic [DATA_W-1:0] r1_d, r1_q;
    logic [DATA_W-1:0] acc_d, acc_q;
    logic [DATA_W-1:0] sig_d, sig_q;
    logic [DATA_W-1:0] cnt_d, cnt_q;
    logic [6:0]        pop_d, pop_q;
    logic              cy_d, cy_q;
    logic              z_d, z_q;
    logic              ovf_d, ovf_q;

    always_comb begin
        a  = in_flat[63:0];
        b  = in_flat[127:64];
        c  = in_flat[191:128];
        d  = in_flat[255:192];
        op = in_flat[257:256];

        lane0 = lane_op(op, a, b);
        lane1 = lane_op(op, c, d);

        r0_d = lane0;
        r1_d = lane1;

        acc_sum = acc_add(acc_q, lane0);
        acc_d   = acc_sum[DATA_W-1:0];
        ovf_d   = ovf_q | acc_sum[DATA_W];

        sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ lane1;
        cnt_d = cnt_q + 64'd1;

        pop_d = popcount(lane0);
        z_d   = (lane0 == '0);

        // For add, the wrapped sum is below an operand exactly when it carried.
        case (op)
            2'b00:   cy_d = (lane0 < a);
            2'b01:   cy_d = (a < b);
            default: cy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_q  <= '0;
            r1_q  <= '0;
            acc_q <= ACC_INIT;
            sig_q <= '0;
            cnt_q <= '0;
            pop_q <= '0;
            cy_q  <= 1'b0;
            z_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            r0_q  <= r0_d;
            r1_q  <= r1_d;
            acc_q <= acc_d;
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            pop_q <= pop_d;
            cy_q  <= cy_d;
            z_q   <= z_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_flat = {ovf_q, z_q, cy_q, pop_q, cnt_q, sig_q, acc_q, r1_q, r0_q};

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top -- self-checking bench for top. A behavioural model tracks every
// output field from the arithmetic rules; a compare process checks the DUT
// against it on every falling clock edge and immediately after an async
// reset assertion. Directed literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_top;

    localparam logic [63:0] ACC_INIT = 64'h0;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB      = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [257:0] in_flat;
    logic [329:0] out_flat;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    event chk_now;

    logic [63:0] m_r0, m_r1, m_acc, m_sig, m_cnt;
    int          m_pop;
    bit          m_cy, m_z, m_ovf;

    top #(.ACC_INIT(ACC_INIT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_flat (in_flat),
        .out_flat(out_flat)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lane(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
        case (op)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x ^ y;
        endcase
    endfunction

    function automatic logic [257:0] pack(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] d);
        return {op, d, c, b, a};
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [257:0] rnd();
        logic [1:0] op;
        op = 2'($urandom_range(0, 3));
        return pack(op, r64(), r64(), r64(), r64());
    endfunction

    task automatic model_reset();
        m_r0 = '0; m_r1 = '0; m_sig = '0; m_cnt = '0;
        m_acc = ACC_INIT; m_pop = 0; m_cy = 0; m_z = 0; m_ovf = 0;
    endtask

    task automatic model_step(input logic [257:0] v);
        logic [63:0]  a, b, c, d, l0, l1;
        logic [1:0]   op;
        logic [127:0] wide;
        a = v[63:0]; b = v[127:64]; c = v[191:128]; d = v[255:192]; op = v[257:256];
        l0 = lane(op, a, b);
        l1 = lane(op, c, d);
        m_r0  = l0;
        m_r1  = l1;
        m_pop = $countones(l0);
        m_z   = (l0 == 64'd0);
        wide  = 128'(a) + 128'(b);
        if (op == 2'd0)      m_cy = (wide > 128'(ONES));
        else if (op == 2'd1) m_cy = (a < b);
        else                 m_cy = 1'b0;
        wide = 128'(m_acc) + 128'(l0);
        if (wide > 128'(ONES)) m_ovf = 1'b1;
`ifdef TOP_ACC_SAT_EN
        m_acc = (wide > 128'(ONES)) ? ONES : wide[63:0];
`else
        m_acc = wide[63:0];
`endif
        m_sig = {m_sig[62:0], m_sig[63]} ^ l1;
        m_cnt = m_cnt + 64'd1;
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every field against the model.
    always begin
        @(negedge clk or chk_now);
        if (chk_en) begin
            chk64("r0",  out_flat[63:0],    m_r0);
            chk64("r1",  out_flat[127:64],  m_r1);
            chk64("acc", out_flat[191:128], m_acc);
            chk64("sig", out_flat[255:192], m_sig);
            chk64("cnt", out_flat[319:256], m_cnt);
            chk64("pop", {57'd0, out_flat[326:320]}, 64'(m_pop));
            chk64("cy",  {63'd0, out_flat[327]}, {63'd0, m_cy});
            chk64("z",   {63'd0, out_flat[328]}, {63'd0, m_z});
            chk64("ovf", {63'd0, out_flat[329]}, {63'd0, m_ovf});
        end
    end

    // Applies v, lets one rising edge consume it, returns 2 time units later.
    task automatic cycle(input logic [257:0] v);
        in_flat = v;
        @(posedge clk);
        if (rst_n) model_step(v);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        -> chk_now;
        #1;
    endtask

    initial begin
        rst_n   = 1'b1;
        in_flat = '0;
        model_reset();
        #1;
        chk_en = 1'b1;

        // Reset held with random inputs: nothing advances.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(rnd());
        chk64("rst_cnt", out_flat[319:256], 64'd0);
        chk64("rst_acc", out_flat[191:128], ACC_INIT);
        chk64("rst_rest", {out_flat[329:192], out_flat[127:0]} == '0 ? 64'd1 : 64'd0, 64'd1);
        rst_n = 1'b1;

        // Add with carry-out.
        cycle(pack(2'd0, ONES, 64'd1, 64'd0, 64'd0));
        chk64("add_r0",  out_flat[63:0], 64'd0);
        chk64("add_z",   {63'd0, out_flat[328]}, 64'd1);
        chk64("add_cy",  {63'd0, out_flat[327]}, 64'd1);
        chk64("add_pop", {57'd0, out_flat[326:320]}, 64'd0);

        // Subtract with borrow.
        cycle(pack(2'd1, 64'd5, 64'd7, 64'd0, 64'd0));
        chk64("sub_r0",  out_flat[63:0], 64'hFFFF_FFFF_FFFF_FFFE);
        chk64("sub_cy",  {63'd0, out_flat[327]}, 64'd1);
        chk64("sub_z",   {63'd0, out_flat[328]}, 64'd0);
        chk64("sub_pop", {57'd0, out_flat[326:320]}, 64'd63);

        // Accumulator overflow.
        do_reset();
        rst_n = 1'b1;
        cycle(pack(2'd0, MSB, 64'd0, 64'd0, 64'd0));
        chk64("acc1", out_flat[191:128], MSB);
        chk64("ovf1", {63'd0, out_flat[329]}, 64'd0);
        cycle(pack(2'd0, MSB, 64'd0, 64'd0, 64'd0));
`ifdef TOP_ACC_SAT_EN
        chk64("acc2", out_flat[191:128], ONES);
`else
        chk64("acc2", out_flat[191:128], 64'd0);
`endif
        chk64("ovf2", {63'd0, out_flat[329]}, 64'd1);
        cycle(pack(2'd0, MSB, 64'd0, 64'd0, 64'd0));
`ifdef TOP_ACC_SAT_EN
        chk64("acc3", out_flat[191:128], ONES);
`else
        chk64("acc3", out_flat[191:128], MSB);
`endif
        chk64("ovf3", {63'd0, out_flat[329]}, 64'd1);

        // Signature and logic ops.
        do_reset();
        rst_n = 1'b1;
        cycle(pack(2'd3, 64'd0, 64'd0, 64'd1, 64'd0));
        chk64("sig1", out_flat[255:192], 64'd1);
        chk64("r1_xor", out_flat[127:64], 64'd1);
        cycle(pack(2'd3, 64'd0, 64'd0, 64'd1, 64'd0));
        chk64("sig2", out_flat[255:192], 64'd3);
        cycle(pack(2'd2, 64'd0, 64'd0, 64'hF0, 64'hF0));
        chk64("r1_and", out_flat[127:64], 64'hF0);

        // Counter over 100 random cycles, then a mid-run reset.
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) cycle(rnd());
        chk64("cnt100", out_flat[319:256], 64'd100);
        for (int i = 0; i < 5; i++) cycle(rnd());
        do_reset();
        chk64("mid_cnt", out_flat[319:256], 64'd0);
        chk64("mid_acc", out_flat[191:128], ACC_INIT);
        chk64("mid_sig", out_flat[255:192], 64'd0);
        cycle(rnd());
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle(rnd());
        chk64("cnt_after", out_flat[319:256], 64'd10);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
